cr_osf_ob_rx: RTL and testbench
===============================

Name: cr_osf_ob_rx

Overview:
Receive-side endpoint for the engine's outbound AXI4-stream datapath, i.e. the consumer of an output-frame-stage stream. Accepts 64-bit beats through a registered-ready skid FIFO and forwards them unchanged downstream. Produces per-beat byte/frame statistic strobes and a per-frame byte length, and flags framing/strobe protocol violations. Sits at the ingress of the next engine stage, ahead of its parser.

Parameters:
DEPTH, 2, skid FIFO entries (min 2); in_tready is registered, so 2 is the minimum for full throughput
LEN_W, 16, frame length accumulator width (saturating)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_tvalid  in  1  upstream beat valid
in_tlast  in  1  last beat of frame
in_tid  in  1  stream id
in_tstrb  in  8  byte strobes, LSB = byte 0
in_tuser  in  8  sideband, passed through
in_tdata  in  64  payload
in_tready  out  1  registered ready to upstream
sup_halt  in  1  supervisor halt: stop accepting, keep draining
out_tvalid  out  1  downstream beat valid
out_tlast / out_tid / out_tstrb / out_tuser / out_tdata  out  1/1/8/8/64  FIFO head fields
out_tready  in  1  downstream ready
ib_bytes_cnt_stb  out  1  pulse: beat accepted
ib_bytes_cnt_amt  out  4  popcount(tstrb) of that beat, 0..8
ib_frame_cnt_stb  out  1  pulse: tlast beat accepted
frame_len  out  LEN_W  bytes in completed frame, valid with frame_len_vld
frame_len_vld  out  1  pulse
strb_err  out  1  pulse: strobe violation on accepted beat
tid_err  out  1  pulse: tid changed mid-frame

Behaviour:
- Reset values: in_tready=0; out_tvalid=0; all out_* data fields=0; all strobes/errors=0; frame_len=0; FIFO count=0; frame state IDLE; accumulator=0.
- Accept: push = in_tvalid & in_tready. Pop = out_tvalid & out_tready. Count updates by push-pop.
- in_tready register: next = (count_next < DEPTH) & ~sup_halt. in_tready is 0 in the first cycle after reset release, and 1 from the following cycle.
- Halt timing: halt asserted in cycle N drops in_tready at N+1. Beats already in the FIFO continue to drain.
- Overflow is structurally impossible. The bench asserts push never occurs with count==DEPTH.
- out_tvalid = (count != 0). Head fields are driven from the FIFO head register.
- Minimum latency: a beat pushed in cycle N is presented in N+1.
- Ordering is strict FIFO; the read pointer wraps modulo DEPTH.
- Simultaneous push and pop at count==DEPTH cannot occur, because ready is low. Push+pop at count==1 keeps count at 1 and sustains throughput.
- Downstream may hold out_tready low indefinitely. The head must stay stable while out_tvalid=1 and out_tready=0.
- Stats are registered and computed on push, with 1-cycle latency:
  - ib_bytes_cnt_stb=1 and ib_bytes_cnt_amt=popcount(in_tstrb) in cycle N+1 for a push in N.
  - ib_frame_cnt_stb=1 in N+1 if that beat has tlast.
- Frame FSM, states IDLE and IN_FRAME, advancing on push only:
  - IDLE --push & ~tlast--> IN_FRAME; latch in_tid; acc = popcount.
  - IDLE --push & tlast--> IDLE (single-beat frame).
  - IN_FRAME --push & ~tlast--> IN_FRAME; acc += popcount, saturating at 2^LEN_W-1.
  - IN_FRAME --push & tlast--> IDLE.
- Frame completion: on a tlast push, frame_len = saturating(acc_prev + popcount) and frame_len_vld pulses in N+1. acc_prev is 0 when coming from IDLE. frame_len holds until the next completion.
- strb_err pulses in N+1 for a pushed beat when either:
  - tstrb is not of form 2^k-1 (ones contiguous from LSB, including 0x00 and 0xFF); or
  - ~tlast and tstrb != 0xFF.
  The beat is still forwarded and counted.
- tid_err pulses when a push in IN_FRAME has in_tid != latched tid. The beat is forwarded and the frame continues with the original tid.
- Zero-byte tlast beat (tstrb=0x00) is legal: frame_len = acc, strb_err=0.
- Reset mid-operation is asynchronous: FIFO contents are discarded and all state and outputs return to reset values immediately. No partial-frame strobe is produced after reset.
- All strobes are single-cycle.

Test Plan:
- Basic frame: 3 beats, tstrb FF,FF,0F with tlast on beat 3, out_tready=1.
  - out_tvalid beats appear 1 cycle after each push, unchanged.
  - ib_bytes_cnt_amt sequence is 8,8,4.
  - ib_frame_cnt_stb pulses once; frame_len=20 with frame_len_vld.
- Backpressure: out_tready=0 while sending 4 beats.
  - in_tready falls after 2 beats are buffered; no beat is lost or reordered.
  - Release out_tready=1: beats drain in order and in_tready returns.
- Halt: assert sup_halt mid-frame for 5 cycles.
  - in_tready=0 from the next cycle; the FIFO drains.
  - Deassert: accept resumes; frame_len is correct across the gap.
- Strobe errors:
  - Non-last beat tstrb=0x7F -> strb_err=1, amt=7.
  - Last beat tstrb=0x05 -> strb_err=1, amt=2; frame_len still reported.
- tid and saturation (LEN_W=4):
  - tid flips on beat 2 of 3 -> single tid_err pulse.
  - 3 full beats (24 bytes) -> frame_len=15.
- Reset mid-frame with 2 beats buffered:
  - All outputs go to 0 immediately; no frame_len_vld is produced.
  - The next frame after reset is counted from 0.

Source files
------------

// File: rtl/cr_osf_ob_rx.sv
// cr_osf_ob_rx: receive endpoint for the outbound AXI4-stream datapath.
// Beats enter through a small skid FIFO with a registered in_tready and are
// forwarded unchanged. The block also produces registered per-beat byte/frame
// statistic strobes, a saturating per-frame byte length, and single-cycle
// flags for strobe-shape and tid-continuity violations.
module cr_osf_ob_rx #(
    parameter int DEPTH = 2,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_tvalid,
    input  logic             in_tlast,
    input  logic             in_tid,
    input  logic [7:0]       in_tstrb,
    input  logic [7:0]       in_tuser,
    input  logic [63:0]      in_tdata,
    output logic             in_tready,

    input  logic             sup_halt,

    output logic             out_tvalid,
    output logic             out_tlast,
    output logic             out_tid,
    output logic [7:0]       out_tstrb,
    output logic [7:0]       out_tuser,
    output logic [63:0]      out_tdata,
    input  logic             out_tready,

    output logic             ib_bytes_cnt_stb,
    output logic [3:0]       ib_bytes_cnt_amt,
    output logic             ib_frame_cnt_stb,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_len_vld,
    output logic             strb_err,
    output logic             tid_err
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WORD_W = 1 + 1 + 8 + 8 + 64;
    localparam int SUM_W  = LEN_W + 4;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = {LEN_W{1'b1}};

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_IN_FRAME = 1'b1;

    // Number of set bits in a byte strobe (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] s);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, s[i]};
        end
        return cnt;
    endfunction

    // True when the strobe is 2^k-1: ones packed from bit 0 with no holes.
    // Adding one turns the low run of ones into a single carry bit, so the
    // AND is zero only for contiguous-from-LSB patterns (0x00 and 0xFF too).
    function automatic logic strb_contig(input logic [7:0] s);
        logic [7:0] s_inc;
        s_inc = s + 8'd1;
        return ((s & s_inc) == 8'h00);
    endfunction

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_tready_q, in_tready_d;

    logic              push;
    logic              pop;
    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] head_word;

    // ------------------------------------------------------------------
    // Statistic / frame state
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic             tid_q, tid_d;
    logic [LEN_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic             frame_len_vld_q, frame_len_vld_d;
    logic             bytes_stb_q, bytes_stb_d;
    logic [3:0]       bytes_amt_q, bytes_amt_d;
    logic             frame_stb_q, frame_stb_d;
    logic             strb_err_q, strb_err_d;
    logic             tid_err_q, tid_err_d;

    logic [3:0]       beat_bytes;
    logic [LEN_W-1:0] acc_base;
    logic [SUM_W-1:0] sum_wide;
    logic [LEN_W-1:0] sum_sat;

    // Handshakes and head presentation come straight from registers.
    assign push       = in_tvalid & in_tready_q;
    assign out_tvalid = (count_q != '0);
    assign pop        = out_tvalid & out_tready;
    assign in_word    = {in_tlast, in_tid, in_tstrb, in_tuser, in_tdata};
    assign head_word  = mem_q[rd_ptr_q];
    assign {out_tlast, out_tid, out_tstrb, out_tuser, out_tdata} = head_word;
    assign in_tready  = in_tready_q;

    // FIFO next-state: storage write, pointer wrap, occupancy and ready.
    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no
        // path can leave it unassigned, which would infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_word;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Ready looks at the post-update occupancy so a full FIFO never sees
        // another push; halt only gates acceptance, draining continues.
        in_tready_d = (count_d < DEPTH_C) & ~sup_halt;
    end

    // FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset because the head fields are visible
            // outputs that must read zero out of reset; at this depth the
            // extra reset fan-out is negligible.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_tready_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples the pre-edge values regardless of order.
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_tready_q <= in_tready_d;
        end
    end

    // Saturating byte accumulation for the beat being pushed this cycle.
    always_comb begin
        beat_bytes = popcount8(in_tstrb);
        acc_base   = (state_q == ST_IN_FRAME) ? acc_q : '0;
        sum_wide   = {4'b0000, acc_base} + {{LEN_W{1'b0}}, beat_bytes};
        sum_sat    = (sum_wide > {4'b0000, LEN_MAX}) ? LEN_MAX
                                                     : sum_wide[LEN_W-1:0];
    end

    // Frame FSM, statistics and protocol checks; all advance on push only.
    always_comb begin
        state_d         = state_q;
        tid_d           = tid_q;
        acc_d           = acc_q;
        frame_len_d     = frame_len_q;
        frame_len_vld_d = 1'b0;
        bytes_stb_d     = push;
        bytes_amt_d     = push ? beat_bytes : 4'd0;
        frame_stb_d     = push & in_tlast;
        strb_err_d      = 1'b0;
        tid_err_d       = 1'b0;

        if (push) begin
            // Only a frame's last beat may be partial, and any strobe must
            // be packed from byte 0.
            strb_err_d = ~strb_contig(in_tstrb) |
                         (~in_tlast & (in_tstrb != 8'hFF));
            // A mismatching beat is still forwarded; the frame keeps the tid
            // latched on its first beat.
            tid_err_d  = (state_q == ST_IN_FRAME) & (in_tid != tid_q);

            if (in_tlast) begin
                frame_len_d     = sum_sat;
                frame_len_vld_d = 1'b1;
                acc_d           = '0;
                state_d         = ST_IDLE;
            end else begin
                acc_d = sum_sat;
                if (state_q == ST_IDLE) begin
                    tid_d   = in_tid;
                    state_d = ST_IN_FRAME;
                end
            end
        end
    end

    // Frame and statistic registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            tid_q           <= 1'b0;
            acc_q           <= '0;
            frame_len_q     <= '0;
            frame_len_vld_q <= 1'b0;
            bytes_stb_q     <= 1'b0;
            bytes_amt_q     <= 4'd0;
            frame_stb_q     <= 1'b0;
            strb_err_q      <= 1'b0;
            tid_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            tid_q           <= tid_d;
            acc_q           <= acc_d;
            frame_len_q     <= frame_len_d;
            frame_len_vld_q <= frame_len_vld_d;
            bytes_stb_q     <= bytes_stb_d;
            bytes_amt_q     <= bytes_amt_d;
            frame_stb_q     <= frame_stb_d;
            strb_err_q      <= strb_err_d;
            tid_err_q       <= tid_err_d;
        end
    end

    assign ib_bytes_cnt_stb = bytes_stb_q;
    assign ib_bytes_cnt_amt = bytes_amt_q;
    assign ib_frame_cnt_stb = frame_stb_q;
    assign frame_len        = frame_len_q;
    assign frame_len_vld    = frame_len_vld_q;
    assign strb_err         = strb_err_q;
    assign tid_err          = tid_err_q;

endmodule

// File: tb/tb_cr_osf_ob_rx.sv
// Directed testbench for cr_osf_ob_rx. A second instance with LEN_W=4 shares
// all inputs and is only inspected for frame-length saturation.
module tb_cr_osf_ob_rx;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        in_tvalid;
    logic        in_tlast;
    logic        in_tid;
    logic [7:0]  in_tstrb;
    logic [7:0]  in_tuser;
    logic [63:0] in_tdata;
    logic        in_tready;
    logic        sup_halt;
    logic        out_tvalid;
    logic        out_tlast;
    logic        out_tid;
    logic [7:0]  out_tstrb;
    logic [7:0]  out_tuser;
    logic [63:0] out_tdata;
    logic        out_tready;
    logic        ib_bytes_cnt_stb;
    logic [3:0]  ib_bytes_cnt_amt;
    logic        ib_frame_cnt_stb;
    logic [15:0] frame_len;
    logic        frame_len_vld;
    logic        strb_err;
    logic        tid_err;

    logic        s_in_tready;
    logic        s_out_tvalid;
    logic        s_out_tlast;
    logic        s_out_tid;
    logic [7:0]  s_out_tstrb;
    logic [7:0]  s_out_tuser;
    logic [63:0] s_out_tdata;
    logic        s_bytes_stb;
    logic [3:0]  s_bytes_amt;
    logic        s_frame_stb;
    logic [3:0]  s_frame_len;
    logic        s_frame_len_vld;
    logic        s_strb_err;
    logic        s_tid_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int occ      = 0;
    logic [63:0] rx_q[$];

    cr_osf_ob_rx #(.DEPTH(DEPTH), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tid(in_tid),
        .in_tstrb(in_tstrb), .in_tuser(in_tuser), .in_tdata(in_tdata),
        .in_tready(in_tready), .sup_halt(sup_halt),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tid(out_tid),
        .out_tstrb(out_tstrb), .out_tuser(out_tuser), .out_tdata(out_tdata),
        .out_tready(out_tready),
        .ib_bytes_cnt_stb(ib_bytes_cnt_stb), .ib_bytes_cnt_amt(ib_bytes_cnt_amt),
        .ib_frame_cnt_stb(ib_frame_cnt_stb), .frame_len(frame_len),
        .frame_len_vld(frame_len_vld), .strb_err(strb_err), .tid_err(tid_err)
    );

    cr_osf_ob_rx #(.DEPTH(DEPTH), .LEN_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tid(in_tid),
        .in_tstrb(in_tstrb), .in_tuser(in_tuser), .in_tdata(in_tdata),
        .in_tready(s_in_tready), .sup_halt(sup_halt),
        .out_tvalid(s_out_tvalid), .out_tlast(s_out_tlast), .out_tid(s_out_tid),
        .out_tstrb(s_out_tstrb), .out_tuser(s_out_tuser), .out_tdata(s_out_tdata),
        .out_tready(out_tready),
        .ib_bytes_cnt_stb(s_bytes_stb), .ib_bytes_cnt_amt(s_bytes_amt),
        .ib_frame_cnt_stb(s_frame_stb), .frame_len(s_frame_len),
        .frame_len_vld(s_frame_len_vld), .strb_err(s_strb_err), .tid_err(s_tid_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream capture and occupancy model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            occ = 0;
        end else begin
            if (in_tvalid && in_tready) begin
                chk_cnt++;
                if (occ >= DEPTH)
                    $display("FAIL overflow: push with occupancy %0d, limit %0d", occ, DEPTH);
                else
                    pass_cnt++;
                occ++;
            end
            if (out_tvalid && out_tready) begin
                rx_q.push_back(out_tdata);
                occ--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic last, input logic id, input logic [7:0] strb,
                         input logic [63:0] data);
        in_tvalid = 1'b1;
        in_tlast  = last;
        in_tid    = id;
        in_tstrb  = strb;
        in_tuser  = data[7:0] ^ 8'h5A;
        in_tdata  = data;
    endtask

    // Present a beat until accepted (bounded); returns at edge+1 of the push.
    task automatic push_beat(input logic last, input logic id, input logic [7:0] strb,
                             input logic [63:0] data, output bit ok);
        bit acc;
        drive(last, id, strb, data);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            acc = in_tready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_tvalid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk_cnt++;
        if ({in_tready, out_tvalid, out_tlast, out_tid, out_tstrb, out_tuser, out_tdata} !== '0)
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h exp all 0", in_tready, out_tvalid, out_tdata);
        else pass_cnt++;
        chk_cnt++;
        if ({ib_bytes_cnt_stb, ib_bytes_cnt_amt, ib_frame_cnt_stb, frame_len, frame_len_vld,
             strb_err, tid_err} !== '0)
            $display("FAIL reset_stats: amt=%0d len=%0d exp all 0", ib_bytes_cnt_amt, frame_len);
        else pass_cnt++;
        rst_n = 1'b1;
        chk_cnt++;
        if (in_tready !== 1'b0) $display("FAIL ready_after_release: got %b exp 0", in_tready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (in_tready !== 1'b1) $display("FAIL ready_second_cycle: got %b exp 1", in_tready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [7:0]  strb_v [3];
        logic [63:0] data_v [3];
        logic [3:0]  amt_v  [3];
        bit ok;
        strb_v = '{8'hFF, 8'hFF, 8'h0F};
        data_v = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h0000_0000_9999_AAAA};
        amt_v  = '{4'd8, 4'd8, 4'd4};
        out_tready = 1'b1;
        rx_q.delete();
        for (int i = 0; i < 3; i++) begin
            push_beat(i == 2, 1'b1, strb_v[i], data_v[i], ok);
            chk_cnt++;
            if (!ok) $display("FAIL basic_accept[%0d]: beat not accepted in time", i);
            else pass_cnt++;
            chk_cnt++;
            if ({out_tvalid, out_tlast, out_tid, out_tstrb, out_tuser, out_tdata} !==
                {1'b1, i == 2, 1'b1, strb_v[i], data_v[i][7:0] ^ 8'h5A, data_v[i]})
                $display("FAIL basic_head[%0d]: vld=%b last=%b strb=%h data=%h exp data %h",
                         i, out_tvalid, out_tlast, out_tstrb, out_tdata, data_v[i]);
            else pass_cnt++;
            chk_cnt++;
            if ({ib_bytes_cnt_stb, ib_bytes_cnt_amt, ib_frame_cnt_stb, strb_err, in_tready} !==
                {1'b1, amt_v[i], i == 2, 1'b0, 1'b1})
                $display("FAIL basic_stats[%0d]: stb=%b amt=%0d fstb=%b serr=%b rdy=%b exp amt %0d",
                         i, ib_bytes_cnt_stb, ib_bytes_cnt_amt, ib_frame_cnt_stb, strb_err,
                         in_tready, amt_v[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({frame_len_vld, frame_len} !== {1'b1, 16'd20})
            $display("FAIL basic_len: vld=%b len=%0d exp 1/20", frame_len_vld, frame_len);
        else pass_cnt++;
        idle(1);
        chk_cnt++;
        if ({out_tvalid, ib_frame_cnt_stb, frame_len_vld, frame_len} !== {3'b000, 16'd20})
            $display("FAIL basic_after: vld=%b fstb=%b lvld=%b len=%0d exp 0/0/0/20",
                     out_tvalid, ib_frame_cnt_stb, frame_len_vld, frame_len);
        else pass_cnt++;
        chk_cnt++;
        if (rx_q.size() != 3 || rx_q[0] !== data_v[0] || rx_q[2] !== data_v[2])
            $display("FAIL basic_order: got %0d beats exp 3", rx_q.size());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [63:0] d [4];
        bit ok0, ok1, ok2, ok3;
        d = '{64'hB0, 64'hB1, 64'hB2, 64'hB3};
        rx_q.delete();
        out_tready = 1'b0;
        push_beat(1'b0, 1'b0, 8'hFF, d[0], ok0);
        push_beat(1'b0, 1'b0, 8'hFF, d[1], ok1);
        chk_cnt++;
        if ({ok0, ok1, in_tready, out_tvalid, out_tdata} !== {4'b1101, d[0]})
            $display("FAIL bp_full: ok=%b%b rdy=%b vld=%b head=%h exp rdy 0 head b0",
                     ok0, ok1, in_tready, out_tvalid, out_tdata);
        else pass_cnt++;
        drive(1'b0, 1'b0, 8'hFF, d[2]);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++;
            if ({in_tready, out_tvalid, out_tdata} !== {2'b01, d[0]})
                $display("FAIL bp_hold[%0d]: rdy=%b vld=%b head=%h exp 0/1/b0",
                         i, in_tready, out_tvalid, out_tdata);
            else pass_cnt++;
        end
        out_tready = 1'b1;
        push_beat(1'b0, 1'b0, 8'hFF, d[2], ok2);
        push_beat(1'b1, 1'b0, 8'hFF, d[3], ok3);
        chk_cnt++;
        if ({ok2, ok3, frame_len_vld, frame_len} !== {3'b111, 16'd32})
            $display("FAIL bp_len: ok=%b%b lvld=%b len=%0d exp 32", ok2, ok3, frame_len_vld, frame_len);
        else pass_cnt++;
        idle(2);
        chk_cnt++;
        if (rx_q.size() != 4 || rx_q[0] !== d[0] || rx_q[1] !== d[1] ||
            rx_q[2] !== d[2] || rx_q[3] !== d[3])
            $display("FAIL bp_order: got %0d beats exp b0,b1,b2,b3", rx_q.size());
        else pass_cnt++;
        chk_cnt++;
        if ({in_tready, out_tvalid} !== 2'b10)
            $display("FAIL bp_drained: rdy=%b vld=%b exp 1/0", in_tready, out_tvalid);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        bit ok;
        rx_q.delete();
        out_tready = 1'b0;
        push_beat(1'b0, 1'b0, 8'hFF, 64'hC0, ok);
        sup_halt   = 1'b1;
        out_tready = 1'b1;
        drive(1'b0, 1'b0, 8'hFF, 64'hC1);
        chk_cnt++;
        if ({ok, in_tready} !== 2'b11)
            $display("FAIL halt_cycle_n: ok=%b rdy=%b exp 1/1", ok, in_tready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({in_tready, out_tvalid, out_tdata} !== {2'b01, 64'hC1})
            $display("FAIL halt_drop: rdy=%b vld=%b head=%h exp 0/1/c1", in_tready, out_tvalid, out_tdata);
        else pass_cnt++;
        drive(1'b1, 1'b0, 8'h03, 64'hC2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_cnt++;
            if ({in_tready, out_tvalid} !== 2'b00)
                $display("FAIL halt_drain[%0d]: rdy=%b vld=%b exp 0/0", i, in_tready, out_tvalid);
            else pass_cnt++;
        end
        sup_halt = 1'b0;
        push_beat(1'b1, 1'b0, 8'h03, 64'hC2, ok);
        chk_cnt++;
        if ({ok, frame_len_vld, frame_len, strb_err} !== {2'b11, 16'd18, 1'b0})
            $display("FAIL halt_len: ok=%b lvld=%b len=%0d serr=%b exp 18", ok, frame_len_vld,
                     frame_len, strb_err);
        else pass_cnt++;
        idle(2);
        chk_cnt++;
        if (rx_q.size() != 3 || rx_q[0] !== 64'hC0 || rx_q[1] !== 64'hC1 || rx_q[2] !== 64'hC2)
            $display("FAIL halt_order: got %0d beats exp c0,c1,c2", rx_q.size());
        else pass_cnt++;
    endtask

    task automatic test_strb_err();
        bit ok;
        out_tready = 1'b1;
        push_beat(1'b0, 1'b0, 8'h7F, 64'hD0, ok);
        chk_cnt++;
        if ({ok, strb_err, ib_bytes_cnt_stb, ib_bytes_cnt_amt} !== {3'b111, 4'd7})
            $display("FAIL strb_nonlast: serr=%b amt=%0d exp 1/7", strb_err, ib_bytes_cnt_amt);
        else pass_cnt++;
        push_beat(1'b1, 1'b0, 8'h05, 64'hD1, ok);
        chk_cnt++;
        if ({ok, strb_err, ib_bytes_cnt_amt, frame_len_vld, frame_len} !==
            {2'b11, 4'd2, 1'b1, 16'd9})
            $display("FAIL strb_last: serr=%b amt=%0d lvld=%b len=%0d exp 1/2/1/9",
                     strb_err, ib_bytes_cnt_amt, frame_len_vld, frame_len);
        else pass_cnt++;
        push_beat(1'b1, 1'b0, 8'h00, 64'hD2, ok);
        chk_cnt++;
        if ({ok, strb_err, ib_bytes_cnt_amt, ib_frame_cnt_stb, frame_len_vld, frame_len} !==
            {2'b10, 4'd0, 2'b11, 16'd0})
            $display("FAIL strb_zero_last: serr=%b amt=%0d lvld=%b len=%0d exp 0/0/1/0",
                     strb_err, ib_bytes_cnt_amt, frame_len_vld, frame_len);
        else pass_cnt++;
        idle(2);
    endtask

    task automatic test_tid_sat();
        bit ok0, ok1, ok2;
        logic e0, e1;
        out_tready = 1'b1;
        push_beat(1'b0, 1'b0, 8'hFF, 64'hE0, ok0);
        e0 = tid_err;
        push_beat(1'b0, 1'b1, 8'hFF, 64'hE1, ok1);
        e1 = tid_err;
        push_beat(1'b1, 1'b0, 8'hFF, 64'hE2, ok2);
        chk_cnt++;
        if ({ok0, ok1, ok2, e0, e1, tid_err} !== 6'b111010)
            $display("FAIL tid_pulse: seq=%b%b%b exp 010", e0, e1, tid_err);
        else pass_cnt++;
        chk_cnt++;
        if ({frame_len_vld, frame_len} !== {1'b1, 16'd24})
            $display("FAIL tid_len: lvld=%b len=%0d exp 24", frame_len_vld, frame_len);
        else pass_cnt++;
        chk_cnt++;
        if ({s_frame_len_vld, s_frame_len} !== {1'b1, 4'd15})
            $display("FAIL sat_len: lvld=%b len=%0d exp 15", s_frame_len_vld, s_frame_len);
        else pass_cnt++;
        idle(2);
    endtask

    task automatic test_reset_mid();
        bit ok0, ok1;
        rx_q.delete();
        out_tready = 1'b0;
        push_beat(1'b0, 1'b1, 8'hFF, 64'hF0, ok0);
        push_beat(1'b0, 1'b1, 8'hFF, 64'hF1, ok1);
        chk_cnt++;
        if ({ok0, ok1, out_tvalid, ib_bytes_cnt_stb, frame_len} !== {4'b1111, 16'd24})
            $display("FAIL rst_pre: vld=%b stb=%b len=%0d exp 1/1/24", out_tvalid,
                     ib_bytes_cnt_stb, frame_len);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({in_tready, out_tvalid, out_tdata, ib_bytes_cnt_stb, ib_bytes_cnt_amt, frame_len} !== '0)
            $display("FAIL rst_immediate: rdy=%b vld=%b data=%h len=%0d exp all 0",
                     in_tready, out_tvalid, out_tdata, frame_len);
        else pass_cnt++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_cnt++;
        if ({frame_len_vld, ib_frame_cnt_stb, out_tvalid, in_tready} !== 4'b0001)
            $display("FAIL rst_no_stb: lvld=%b fstb=%b vld=%b rdy=%b exp 0/0/0/1",
                     frame_len_vld, ib_frame_cnt_stb, out_tvalid, in_tready);
        else pass_cnt++;
        out_tready = 1'b1;
        push_beat(1'b1, 1'b0, 8'h0F, 64'hF2, ok0);
        chk_cnt++;
        if ({ok0, frame_len_vld, frame_len, out_tdata} !== {2'b11, 16'd4, 64'hF2})
            $display("FAIL rst_next_frame: lvld=%b len=%0d head=%h exp 1/4/f2",
                     frame_len_vld, frame_len, out_tdata);
        else pass_cnt++;
        idle(2);
        chk_cnt++;
        if (rx_q.size() != 1 || rx_q[0] !== 64'hF2)
            $display("FAIL rst_discard: got %0d beats exp only f2", rx_q.size());
        else pass_cnt++;
    endtask

    initial begin
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        in_tid     = 1'b0;
        in_tstrb   = 8'h00;
        in_tuser   = 8'h00;
        in_tdata   = 64'h0;
        sup_halt   = 1'b0;
        out_tready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_halt();
        test_strb_err();
        test_tid_sat();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
